id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection, sitting between decode and execute.
- Captures decoded operands and control from ID each cycle.
- Presents rs1/rs2/rd ids and reg_write to the forwarding unit and ALU operand muxes.
- Inserts a one-cycle bubble and stalls IF/ID when an instruction in ID needs a load result still in EX.
- Also handles branch flush, memory-stall freeze and a saturating stall counter.

---
 rtl/id_ex_stage_reg.sv | 119 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// memory-stall freeze and a saturating load-use bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 6,
    parameter int CTRL_WIDTH   = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [REG_ID_WIDTH-1:0] id_rs1,
    input  logic [REG_ID_WIDTH-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic [REG_ID_WIDTH-1:0] id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic [DATA_WIDTH-1:0]   id_data1,
    input  logic [DATA_WIDTH-1:0]   id_data2,
    input  logic [DATA_WIDTH-1:0]   id_imm,
    input  logic [DATA_WIDTH-1:0]   id_pc,
    input  logic [CTRL_WIDTH-1:0]   id_ctrl,
    input  logic                    flush_ex,
    input  logic                    mem_stall,
    output logic                    ex_valid,
    output logic                    ex_reg_write,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic [REG_ID_WIDTH-1:0] ex_rs1,
    output logic [REG_ID_WIDTH-1:0] ex_rs2,
    output logic [REG_ID_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]   ex_data1,
    output logic [DATA_WIDTH-1:0]   ex_data2,
    output logic [DATA_WIDTH-1:0]   ex_imm,
    output logic [DATA_WIDTH-1:0]   ex_pc,
    output logic [CTRL_WIDTH-1:0]   ex_ctrl,
    output logic                    stall_if_id,
    output logic [CNT_WIDTH-1:0]    load_use_cnt
);

    logic                    r_valid, r_reg_write, r_mem_read, r_mem_write;
    logic [REG_ID_WIDTH-1:0] r_rs1, r_rs2, r_rd;
    logic [DATA_WIDTH-1:0]   r_data1, r_data2, r_imm, r_pc;
    logic [CTRL_WIDTH-1:0]   r_ctrl;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    w_src_match;
    logic                    w_hazard;

    assign w_src_match = (id_use_rs1 && (id_rs1 == r_rd)) ||
                         (id_use_rs2 && (id_rs2 == r_rd));
    assign w_hazard    = r_valid && r_mem_read && (r_rd != '0) && id_valid && w_src_match;
    // A taken branch kills the dependent instruction, so no need to hold IF/ID for it.
    assign stall_if_id = mem_stall || (w_hazard && !flush_ex);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_ctrl      <= '0;
            r_cnt       <= '0;
        end else if (mem_stall) begin
            // Freeze; a pending flush re-asserts once the branch can leave EX.
        end else if (flush_ex || w_hazard) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_ctrl      <= '0;
            if (!flush_ex && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end else begin
            r_valid     <= id_valid;
            r_reg_write <= id_valid && id_reg_write;
            r_mem_read  <= id_valid && id_mem_read;
            r_mem_write <= id_valid && id_mem_write;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_data1     <= id_data1;
            r_data2     <= id_data2;
            r_imm       <= id_imm;
            r_pc        <= id_pc;
            r_ctrl      <= id_ctrl;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_data1     = r_data1;
    assign ex_data2     = r_data2;
    assign ex_imm       = r_imm;
    assign ex_pc        = r_pc;
    assign ex_ctrl      = r_ctrl;
    assign load_use_cnt = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg against a reference model
// of the EX-stage contents as a whole record.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int RW = 6;
    localparam int CW = 12;
    localparam int NW = 4;

    typedef struct packed {
        logic          valid, rw, mr, mw;
        logic [RW-1:0] rs1, rs2, rd;
        logic [DW-1:0] d1, d2, imm, pc;
        logic [CW-1:0] ctrl;
        logic [NW-1:0] cnt;
    } st_t;

    typedef struct packed {
        logic          valid, use1, use2, rw, mr, mw, flush, mstall;
        logic [RW-1:0] rs1, rs2, rd;
        logic [DW-1:0] d1, d2, imm, pc;
        logic [CW-1:0] ctrl;
    } in_t;

    logic          clk = 1'b0, reset = 1'b0;
    logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mem_write;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic [DW-1:0] id_data1, id_data2, id_imm, id_pc;
    logic [CW-1:0] id_ctrl;
    logic          flush_ex, mem_stall;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_if_id;
    logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [DW-1:0] ex_data1, ex_data2, ex_imm, ex_pc;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] load_use_cnt;

    int  n_pass = 0, n_tot = 0;
    st_t m;          // model of EX-stage contents
    in_t cur;        // what ID currently presents
    logic exp_stall;

    id_ex_stage_reg #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .flush_ex(flush_ex), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl), .stall_if_id(stall_if_id), .load_use_cnt(load_use_cnt)
    );

    always #5 clk = ~clk;

    function automatic st_t dut_st();
        return '{ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rs1, ex_rs2, ex_rd,
                 ex_data1, ex_data2, ex_imm, ex_pc, ex_ctrl, load_use_cnt};
    endfunction

    // Does the instruction in ID read a register a load in EX has yet to produce?
    function automatic logic needs_bubble(st_t s, in_t i);
        logic reads_it;
        reads_it = (i.use1 && i.rs1 == s.rd) || (i.use2 && i.rs2 == s.rd);
        return s.valid && s.mr && s.rd != 0 && i.valid && reads_it;
    endfunction

    function automatic st_t model_edge(st_t s, in_t i);
        st_t n;
        if (i.mstall) return s;
        n = '0;
        n.cnt = s.cnt;
        if (i.flush) return n;
        if (needs_bubble(s, i)) begin
            n.cnt = (s.cnt == 4'd15) ? s.cnt : s.cnt + 4'd1;
            return n;
        end
        n = '{i.valid, i.valid & i.rw, i.valid & i.mr, i.valid & i.mw, i.rs1, i.rs2, i.rd,
              i.d1, i.d2, i.imm, i.pc, i.ctrl, s.cnt};
        return n;
    endfunction

    function automatic in_t instr(logic v, logic [RW-1:0] rs1, logic u1, logic [RW-1:0] rs2,
                                  logic u2, logic [RW-1:0] rd, logic rw, logic mr);
        in_t i;
        i = '0;
        i.valid = v; i.rs1 = rs1; i.use1 = u1; i.rs2 = rs2; i.use2 = u2;
        i.rd = rd; i.rw = rw; i.mr = mr;
        i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom; i.pc = $urandom;
        i.ctrl = CW'($urandom);
        return i;
    endfunction

    task automatic apply(input in_t i);
        cur = i;
        id_valid = i.valid; id_rs1 = i.rs1; id_rs2 = i.rs2; id_use_rs1 = i.use1;
        id_use_rs2 = i.use2; id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr;
        id_mem_write = i.mw; id_data1 = i.d1; id_data2 = i.d2; id_imm = i.imm;
        id_pc = i.pc; id_ctrl = i.ctrl; flush_ex = i.flush; mem_stall = i.mstall;
        #1;
        exp_stall = i.mstall || (needs_bubble(m, i) && !i.flush);
    endtask

    task automatic tick();
        @(posedge clk);
        m = model_edge(m, cur);
        #1;
    endtask

    task automatic test_reset();
        in_t i;
        i = instr(1'b0, 0, 0, 0, 0, 0, 0, 0);
        i.mstall = 1'b1;
        reset = 1'b1;
        apply(i);
        m = '0;
        n_tot++;
        if (dut_st() !== m) $display("FAIL reset_state got %h want %h", dut_st(), m);
        else n_pass++;
        n_tot++;
        if (stall_if_id !== 1'b1) $display("FAIL reset_stall_memstall got %b want 1", stall_if_id);
        else n_pass++;
        i.mstall = 1'b0;
        apply(i);
        n_tot++;
        if (stall_if_id !== 1'b0) $display("FAIL reset_stall_idle got %b want 0", stall_if_id);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_add();
        apply(instr(1'b1, 3, 1, 4, 1, 5, 1, 0));
        n_tot++;
        if (stall_if_id !== 1'b0) $display("FAIL add_stall got %b want 0", stall_if_id);
        else n_pass++;
        tick();
        n_tot++;
        if (ex_rd !== 6'd5 || ex_reg_write !== 1'b1 || ex_valid !== 1'b1)
            $display("FAIL add_ex got rd=%0d rw=%b v=%b want rd=5 rw=1 v=1", ex_rd, ex_reg_write, ex_valid);
        else n_pass++;
        n_tot++;
        if (dut_st() !== m) $display("FAIL add_state got %h want %h", dut_st(), m);
        else n_pass++;
    endtask

    task automatic test_load_use();
        in_t add_i;
        logic [NW-1:0] c0;
        c0 = m.cnt;
        apply(instr(1'b1, 1, 1, 2, 0, 7, 1, 1));
        tick();
        add_i = instr(1'b1, 7, 1, 9, 1, 10, 1, 0);
        apply(add_i);
        n_tot++;
        if (stall_if_id !== 1'b1) $display("FAIL lu_stall got %b want 1", stall_if_id);
        else n_pass++;
        tick();
        n_tot++;
        if (ex_valid !== 1'b0 || ex_rd !== 6'd0 || load_use_cnt !== c0 + 4'd1)
            $display("FAIL lu_bubble got v=%b rd=%0d cnt=%0d want v=0 rd=0 cnt=%0d",
                     ex_valid, ex_rd, load_use_cnt, c0 + 4'd1);
        else n_pass++;
        apply(add_i);
        n_tot++;
        if (stall_if_id !== 1'b0) $display("FAIL lu_release got %b want 0", stall_if_id);
        else n_pass++;
        tick();
        n_tot++;
        if (dut_st() !== m || ex_rd !== 6'd10) $display("FAIL lu_add_enters got %h want %h", dut_st(), m);
        else n_pass++;
    endtask

    task automatic test_no_false_stall();
        logic [NW-1:0] c0;
        c0 = m.cnt;
        apply(instr(1'b1, 1, 1, 2, 0, 0, 1, 1));
        tick();
        apply(instr(1'b1, 0, 1, 0, 1, 4, 1, 0));
        n_tot++;
        if (stall_if_id !== 1'b0) $display("FAIL rd0_stall got %b want 0", stall_if_id);
        else n_pass++;
        apply(instr(1'b1, 1, 1, 2, 0, 7, 1, 1));
        tick();
        apply(instr(1'b1, 3, 1, 7, 0, 4, 1, 0));
        n_tot++;
        if (stall_if_id !== 1'b0) $display("FAIL unused_rs2_stall got %b want 0", stall_if_id);
        else n_pass++;
        tick();
        n_tot++;
        if (ex_valid !== 1'b1 || load_use_cnt !== c0 || dut_st() !== m)
            $display("FAIL no_bubble got %h want %h", dut_st(), m);
        else n_pass++;
    endtask

    task automatic test_flush_priority();
        in_t i;
        logic [NW-1:0] c0;
        c0 = m.cnt;
        apply(instr(1'b1, 1, 1, 2, 0, 7, 1, 1));
        tick();
        i = instr(1'b1, 7, 1, 2, 0, 8, 1, 0);
        i.flush = 1'b1;
        apply(i);
        n_tot++;
        if (stall_if_id !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_if_id);
        else n_pass++;
        tick();
        n_tot++;
        if (ex_valid !== 1'b0 || ex_rd !== 6'd0 || load_use_cnt !== c0)
            $display("FAIL flush_bubble got v=%b rd=%0d cnt=%0d want v=0 rd=0 cnt=%0d",
                     ex_valid, ex_rd, load_use_cnt, c0);
        else n_pass++;
    endtask

    task automatic test_freeze();
        in_t i;
        st_t held;
        apply(instr(1'b1, 3, 1, 4, 1, 5, 1, 0));
        tick();
        held = dut_st();
        i = instr(1'b1, 5, 1, 6, 1, 9, 1, 0);
        i.flush = 1'b1;
        i.mstall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(i);
            n_tot++;
            if (stall_if_id !== 1'b1) $display("FAIL freeze_stall%0d got %b want 1", k, stall_if_id);
            else n_pass++;
            tick();
            n_tot++;
            if (dut_st() !== held || ex_rd !== 6'd5) $display("FAIL freeze_hold%0d got %h want %h", k, dut_st(), held);
            else n_pass++;
        end
        i.mstall = 1'b0;
        apply(i);
        tick();
        n_tot++;
        if (ex_valid !== 1'b0 || ex_rd !== 6'd0) $display("FAIL freeze_release got v=%b rd=%0d want v=0 rd=0", ex_valid, ex_rd);
        else n_pass++;
    endtask

    task automatic test_random();
        in_t i;
        int errs = 0;
        for (int k = 0; k < 400; k++) begin
            i = instr($urandom_range(3, 0) != 0, RW'($urandom_range(7, 0)), 1'($urandom),
                      RW'($urandom_range(7, 0)), 1'($urandom), RW'($urandom_range(7, 0)),
                      1'($urandom), $urandom_range(2, 0) == 0);
            i.mw = 1'($urandom);
            i.flush = $urandom_range(7, 0) == 0;
            i.mstall = $urandom_range(7, 0) == 0;
            apply(i);
            n_tot++;
            if (stall_if_id !== exp_stall) begin
                $display("FAIL rand_stall@%0d got %b want %b", k, stall_if_id, exp_stall);
                errs++;
            end else n_pass++;
            tick();
            n_tot++;
            if (dut_st() !== m) begin
                $display("FAIL rand_state@%0d got %h want %h", k, dut_st(), m);
                errs++;
            end else n_pass++;
            if (errs > 10) break;
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 17; k++) begin
            apply(instr(1'b1, 1, 0, 2, 0, 7, 1, 1));
            tick();
            apply(instr(1'b1, 2, 0, 7, 1, 3, 1, 0));
            tick();
            tick();
        end
        n_tot++;
        if (load_use_cnt !== 4'hF || m.cnt !== 4'hF) $display("FAIL sat_cnt got %0d want 15", load_use_cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply(instr(1'b1, 1, 1, 2, 1, 7, 1, 1));
        tick();
        apply(instr(1'b1, 7, 1, 2, 0, 3, 1, 0));
        n_tot++;
        if (stall_if_id !== 1'b1) $display("FAIL ar_prestall got %b want 1", stall_if_id);
        else n_pass++;
        #2 reset = 1'b1;
        m = '0;
        #1;
        n_tot++;
        if (dut_st() !== m || stall_if_id !== 1'b0)
            $display("FAIL ar_clear got %h stall=%b want %h stall=0", dut_st(), stall_if_id, m);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        apply(cur);
        tick();
        n_tot++;
        if (dut_st() !== m || ex_valid !== 1'b1 || ex_rd !== 6'd3)
            $display("FAIL ar_first_load got %h want %h", dut_st(), m);
        else n_pass++;
    endtask

    initial begin
        m = '0;
        test_reset();
        test_basic_add();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_freeze();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
